// File: rtl/axis_oq_word_packer_if.sv
// rtl/axis_oq_word_packer_if.sv - packet stream in, memory-word stream out, for the output-queue packer
interface axis_oq_word_packer_if #(
   parameter int IN_WIDTH    = 256,
   parameter int MEM_WIDTH   = 64,
   parameter int TUSER_WIDTH = 128,
   parameter int QID_WIDTH   = 3
);
   localparam int BYTES_W = $clog2(MEM_WIDTH / 8) + 1;

   logic                   s_axis_tvalid;
   logic                   s_axis_tready;
   logic [IN_WIDTH-1:0]    s_axis_tdata;
   logic [IN_WIDTH/8-1:0]  s_axis_tstrb;
   logic [TUSER_WIDTH-1:0] s_axis_tuser;
   logic                   s_axis_tlast;

   logic                   m_word_valid;
   logic                   m_word_ready;
   logic [MEM_WIDTH-1:0]   m_word_data;
   logic [QID_WIDTH-1:0]   m_word_qid;
   logic                   m_word_sop;
   logic                   m_word_eop;
   logic [BYTES_W-1:0]     m_word_bytes;

   // slave: the packer (stream sink, word source); master: its surroundings
   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast,
      output s_axis_tready,
      output m_word_valid, m_word_data, m_word_qid, m_word_sop, m_word_eop, m_word_bytes,
      input  m_word_ready
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast,
      input  s_axis_tready,
      input  m_word_valid, m_word_data, m_word_qid, m_word_sop, m_word_eop, m_word_bytes,
      output m_word_ready
   );
endinterface

// File: rtl/axis_oq_word_packer.sv
// rtl/axis_oq_word_packer.sv - reserves per-queue word budget at packet start and serialises
// admitted packets into a header word plus memory-width data words
module axis_oq_word_packer #(
   parameter int IN_WIDTH    = 256,
   parameter int MEM_WIDTH   = 64,
   parameter int TUSER_WIDTH = 128,
   parameter int NUM_QUEUES  = 8,
   parameter int QID_WIDTH   = 3,
   parameter int QUEUE_WORDS = 65536,
   parameter int CNT_WIDTH   = 17,
   parameter int DST_POS     = 24
) (
   input  logic                             clk,
   input  logic                             reset,
   axis_oq_word_packer_if.slave             bus,
   input  logic                             release_valid,
   input  logic [QID_WIDTH-1:0]             release_qid,
   input  logic [CNT_WIDTH-1:0]             release_words,
   output logic [NUM_QUEUES*CNT_WIDTH-1:0]  free_words,
   output logic [31:0]                      drop_count,
   output logic                             err_overrun
);
   localparam int R       = IN_WIDTH / MEM_WIDTH;
   localparam int BYTES   = MEM_WIDTH / 8;
   localparam int BYTES_W = $clog2(BYTES) + 1;
   localparam int SL_W    = (R > 1) ? $clog2(R) : 1;
   localparam int NEED_W  = ((CNT_WIDTH > 17) ? CNT_WIDTH : 17) + 1;
   localparam int SUM_W   = NEED_W + 2;

   typedef enum logic [2:0] {IDLE, HDR, SER, WAIT, DROP} state_t;

   state_t                 state;
   logic [IN_WIDTH-1:0]    beat_data;
   logic [IN_WIDTH/8-1:0]  beat_strb;
   logic                   beat_last;
   logic [MEM_WIDTH-1:0]   hdr_word;
   logic [QID_WIDTH-1:0]   qid_r;
   logic [NEED_W-1:0]      need_r;
   logic [NEED_W-1:0]      emitted_r;
   logic [SL_W-1:0]        slice_r;
   logic [CNT_WIDTH-1:0]   free_r    [NUM_QUEUES];
   logic [CNT_WIDTH-1:0]   free_next [NUM_QUEUES];

   logic [NUM_QUEUES-1:0]  dst_field;
   logic                   dst_ok;
   logic [QID_WIDTH-1:0]   dst_qid;
   logic [NEED_W-1:0]      need_in;
   logic                   admit;
   logic [SL_W-1:0]        last_slice;
   logic [BYTES-1:0]       cur_strb;
   logic [BYTES_W-1:0]     cur_bytes;
   logic                   at_final;
   logic                   word_valid;
   logic                   word_fire;
   logic                   beat_fire;
   logic [NEED_W-1:0]      emitted_nx;
   logic                   res_en;
   logic                   recon_en;
   logic [NEED_W-1:0]      recon_words;

   always_comb begin
      dst_field = bus.s_axis_tuser[DST_POS +: NUM_QUEUES];
      dst_ok    = |dst_field;
      dst_qid   = '0;
      for (int q = NUM_QUEUES - 1; q >= 0; q--)
         if (dst_field[q]) dst_qid = QID_WIDTH'(q);
      need_in = NEED_W'(1) + (NEED_W'(bus.s_axis_tuser[15:0]) + NEED_W'(BYTES - 1)) / NEED_W'(BYTES);
      admit   = dst_ok && (NEED_W'(free_r[dst_qid]) >= need_in);
   end

   // strobes are contiguous from bit 0, so the highest populated slice ends the beat
   always_comb begin
      last_slice = '0;
      for (int k = 0; k < R; k++)
         if (|beat_strb[k*BYTES +: BYTES]) last_slice = SL_W'(k);
      cur_strb  = beat_strb[int'(slice_r)*BYTES +: BYTES];
      cur_bytes = '0;
      for (int b = 0; b < BYTES; b++)
         cur_bytes = cur_bytes + BYTES_W'(cur_strb[b]);
   end

   assign at_final   = (slice_r == last_slice);
   assign word_valid = !reset && (state == HDR || state == SER);
   assign word_fire  = word_valid && bus.m_word_ready;
   assign beat_fire  = bus.s_axis_tvalid && bus.s_axis_tready;
   assign emitted_nx = (&emitted_r) ? emitted_r : emitted_r + NEED_W'(1);

   always_comb begin
      bus.m_word_valid = word_valid;
      bus.m_word_data  = '0;
      bus.m_word_qid   = '0;
      bus.m_word_sop   = 1'b0;
      bus.m_word_eop   = 1'b0;
      bus.m_word_bytes = '0;
      if (word_valid) begin
         bus.m_word_qid = qid_r;
         if (state == HDR) begin
            bus.m_word_data  = hdr_word;
            bus.m_word_sop   = 1'b1;
            bus.m_word_bytes = BYTES_W'(BYTES);
         end else begin
            bus.m_word_data  = beat_data[int'(slice_r)*MEM_WIDTH +: MEM_WIDTH];
            bus.m_word_eop   = at_final && beat_last;
            bus.m_word_bytes = cur_bytes;
         end
      end
      case (state)
         IDLE, WAIT, DROP: bus.s_axis_tready = 1'b1;
         SER:              bus.s_axis_tready = at_final && bus.m_word_ready && !beat_last;
         default:          bus.s_axis_tready = 1'b0;
      endcase
      if (reset) bus.s_axis_tready = 1'b0;
   end

   assign res_en      = (state == IDLE) && beat_fire && admit;
   assign recon_en    = (state == SER) && word_fire && at_final && beat_last && (emitted_nx < need_r);
   assign recon_words = need_r - emitted_nx;

   // reservation, give-back and release all land in one update; saturation applies to the sum
   always_comb begin
      logic [SUM_W-1:0] sum;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         sum = SUM_W'(free_r[q]);
         if (release_valid && release_qid == QID_WIDTH'(q)) sum = sum + SUM_W'(release_words);
         if (recon_en && qid_r == QID_WIDTH'(q))            sum = sum + SUM_W'(recon_words);
         if (res_en && dst_qid == QID_WIDTH'(q))            sum = sum - SUM_W'(need_in);
         free_next[q] = (sum > SUM_W'(QUEUE_WORDS)) ? CNT_WIDTH'(QUEUE_WORDS) : sum[CNT_WIDTH-1:0];
      end
   end

   for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_free
      assign free_words[q*CNT_WIDTH +: CNT_WIDTH] = free_r[q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         beat_data   <= '0;
         beat_strb   <= '0;
         beat_last   <= 1'b0;
         hdr_word    <= '0;
         qid_r       <= '0;
         need_r      <= '0;
         emitted_r   <= '0;
         slice_r     <= '0;
         drop_count  <= '0;
         err_overrun <= 1'b0;
         for (int q = 0; q < NUM_QUEUES; q++) free_r[q] <= CNT_WIDTH'(QUEUE_WORDS);
      end else begin
         case (state)
            IDLE: if (beat_fire) begin
               if (admit) begin
                  beat_data <= bus.s_axis_tdata;
                  beat_strb <= bus.s_axis_tstrb;
                  beat_last <= bus.s_axis_tlast;
                  hdr_word  <= bus.s_axis_tuser[MEM_WIDTH-1:0];
                  qid_r     <= dst_qid;
                  need_r    <= need_in;
                  emitted_r <= '0;
                  state     <= HDR;
               end else begin
                  drop_count <= drop_count + 32'd1;
                  state      <= bus.s_axis_tlast ? IDLE : DROP;
               end
            end
            HDR: if (bus.m_word_ready) begin
               emitted_r <= emitted_nx;
               slice_r   <= '0;
               state     <= SER;
            end
            SER: if (bus.m_word_ready) begin
               emitted_r <= emitted_nx;
               if (!at_final) begin
                  slice_r <= slice_r + SL_W'(1);
               end else if (beat_last) begin
                  state <= IDLE;
               end else if (beat_fire) begin
                  beat_data <= bus.s_axis_tdata;
                  beat_strb <= bus.s_axis_tstrb;
                  beat_last <= bus.s_axis_tlast;
                  slice_r   <= '0;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: if (beat_fire) begin
               beat_data <= bus.s_axis_tdata;
               beat_strb <= bus.s_axis_tstrb;
               beat_last <= bus.s_axis_tlast;
               slice_r   <= '0;
               state     <= SER;
            end
            DROP: if (beat_fire && bus.s_axis_tlast) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (word_fire && emitted_r >= need_r) err_overrun <= 1'b1;
         for (int q = 0; q < NUM_QUEUES; q++) free_r[q] <= free_next[q];
      end
   end
endmodule

// File: tb/tb_axis_oq_word_packer.sv
// tb/tb_axis_oq_word_packer.sv - directed table-driven bench for axis_oq_word_packer
module tb_axis_oq_word_packer;
   localparam int CW = 17;
   localparam int SCW = 5;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [3:0]  bytes;
      logic [2:0]  qid;
   } word_t;

   typedef struct {
      logic [15:0] len;
      logic [7:0]  dst;
      int          nbeats;
      logic [31:0] lstrb;
      bit          admit;
      int          qid;
      int          exp_words;
      logic [3:0]  exp_lbytes;
      logic [16:0] exp_free;
      logic [31:0] exp_drop;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                 rel_v;
   logic [2:0]           rel_q;
   logic [CW-1:0]        rel_w;
   logic [8*CW-1:0]      free_words;
   logic [31:0]          drop_count;
   logic                 err_overrun;
   logic [8*SCW-1:0]     s_free;
   logic [31:0]          s_drop;
   logic                 s_err;

   axis_oq_word_packer_if #(.IN_WIDTH(256), .MEM_WIDTH(64), .TUSER_WIDTH(128), .QID_WIDTH(3)) bus ();
   axis_oq_word_packer_if #(.IN_WIDTH(256), .MEM_WIDTH(64), .TUSER_WIDTH(128), .QID_WIDTH(3)) sbus ();

   axis_oq_word_packer dut (
      .clk(clk), .reset(reset), .bus(bus.slave),
      .release_valid(rel_v), .release_qid(rel_q), .release_words(rel_w),
      .free_words(free_words), .drop_count(drop_count), .err_overrun(err_overrun)
   );

   axis_oq_word_packer #(.QUEUE_WORDS(16), .CNT_WIDTH(SCW)) u_small (
      .clk(clk), .reset(reset), .bus(sbus.slave),
      .release_valid(1'b0), .release_qid(3'd0), .release_words(5'd0),
      .free_words(s_free), .drop_count(s_drop), .err_overrun(s_err)
   );

   int    checks = 0;
   int    errors = 0;
   word_t exp_q[$];
   word_t got_q[$];
   bit    drv_done;
   int    drv_stalls;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no handshake within the cycle budget", name);
   endtask

   function automatic logic [127:0] mk_tuser(input logic [15:0] len, input logic [7:0] dst, input int tag);
      logic [127:0] t;
      t = '0;
      t[15:0]    = len;
      t[24 +: 8] = dst;
      t[63:32]   = 32'hC0DE_0000 + tag;
      t[127:96]  = 32'hFFFF_FFFF;
      return t;
   endfunction

   function automatic logic [255:0] beat_pat(input int pid, input int b);
      logic [255:0] d;
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = {8'(pid) ^ 8'hA5, 8'(b), 16'(w * 4099 + pid)};
      return d;
   endfunction

   function automatic logic [16:0] free_of(input int q);
      return free_words[q*CW +: CW];
   endfunction

   task automatic run_packet(input logic [127:0] tuser, input int nb, input logic [31:0] lstrb,
                             input bit admit, input logic [2:0] q, input int pid, input bit bp);
      logic [31:0]  s;
      logic [255:0] d;
      int           lastk;
      exp_q.delete();
      got_q.delete();
      if (admit) begin
         exp_q.push_back({tuser[63:0], 1'b1, 1'b0, 4'd8, q});
         for (int b = 0; b < nb; b++) begin
            s = (b == nb - 1) ? lstrb : 32'hFFFF_FFFF;
            d = beat_pat(pid, b);
            lastk = -1;
            for (int k = 0; k < 4; k++) if (s[k*8 +: 8] != 8'h00) lastk = k;
            for (int k = 0; k <= lastk; k++)
               exp_q.push_back({d[k*64 +: 64], 1'b0, (b == nb - 1) && (k == lastk),
                                4'($countones(s[k*8 +: 8])), q});
         end
      end
      drv_done   = 0;
      drv_stalls = 0;
      fork
         begin
            for (int b = 0; b < nb; b++) begin
               bit ok;
               int n;
               bus.s_axis_tvalid = 1'b1;
               bus.s_axis_tdata  = beat_pat(pid, b);
               bus.s_axis_tstrb  = (b == nb - 1) ? lstrb : 32'hFFFF_FFFF;
               bus.s_axis_tlast  = (b == nb - 1);
               bus.s_axis_tuser  = tuser;
               ok = 0;
               n  = 0;
               while (!ok && n < 300) begin
                  @(negedge clk);
                  ok = bus.s_axis_tready;
                  if (!ok) drv_stalls++;
                  @(posedge clk); #1;
                  n++;
               end
               if (!ok) begin
                  timeout_fail("beat_handshake");
                  break;
               end
            end
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tlast  = 1'b0;
            drv_done = 1;
         end
         begin
            int    cyc;
            int    post;
            bit    done;
            bit    stalled;
            word_t held;
            word_t cur;
            cyc = 0; post = 0; done = 0; stalled = 0; held = '0;
            while (!done && cyc < 600) begin
               bus.m_word_ready = bp ? (cyc % 2 == 0) : 1'b1;
               @(negedge clk);
               cur = {bus.m_word_data, bus.m_word_sop, bus.m_word_eop, bus.m_word_bytes, bus.m_word_qid};
               if (stalled) check("stall_hold", {bus.m_word_valid, cur}, {1'b1, held});
               stalled = 0;
               if (bus.m_word_valid) begin
                  if (bus.m_word_ready) begin
                     got_q.push_back(cur);
                     if (cur.eop) done = 1;
                  end else begin
                     held    = cur;
                     stalled = 1;
                  end
               end
               if (drv_done && !admit) begin
                  post++;
                  if (post > 4) done = 1;
               end
               @(posedge clk); #1;
               cyc++;
            end
            bus.m_word_ready = 1'b1;
            if (!done) timeout_fail("word_eop");
         end
      join
      check("word_count_vs_model", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("word%0d_pkt%0d", i, pid), got_q[i], exp_q[i]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      vecs[0] = '{16'd60,  8'h04, 2, 32'h0FFF_FFFF, 1'b1, 2, 9, 4'd4, 17'd65527, 32'd0};
      vecs[1] = '{16'd8,   8'h00, 1, 32'h0000_00FF, 1'b0, 0, 0, 4'd0, 17'd65536, 32'd1};
      vecs[2] = '{16'd64,  8'h40, 1, 32'hFFFF_FFFF, 1'b1, 6, 5, 4'd8, 17'd65531, 32'd1};
      vecs[3] = '{16'd20,  8'h98, 1, 32'h000F_FFFF, 1'b1, 3, 4, 4'd4, 17'd65532, 32'd1};
      vecs[4] = '{16'd100, 8'h00, 3, 32'h0000_000F, 1'b0, 0, 0, 4'd0, 17'd65536, 32'd2};
      vecs[5] = '{16'd32,  8'h04, 1, 32'hFFFF_FFFF, 1'b1, 2, 5, 4'd8, 17'd65522, 32'd2};

      reset = 1'b1;
      rel_v = 1'b0; rel_q = '0; rel_w = '0;
      bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tstrb = '0;
      bus.s_axis_tuser = '0; bus.s_axis_tlast = 1'b0; bus.m_word_ready = 1'b1;
      sbus.s_axis_tvalid = 1'b0; sbus.s_axis_tdata = '0; sbus.s_axis_tstrb = '0;
      sbus.s_axis_tuser = '0; sbus.s_axis_tlast = 1'b0; sbus.m_word_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_tready", bus.s_axis_tready, 1'b0);
      check("reset_valid", bus.m_word_valid, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("idle_tready", bus.s_axis_tready, 1'b1);
      check("idle_valid", bus.m_word_valid, 1'b0);
      check("idle_data", bus.m_word_data, 64'd0);
      check("init_drop", drop_count, 32'd0);
      check("init_err", err_overrun, 1'b0);
      for (int q = 0; q < 8; q++) check($sformatf("init_free%0d", q), free_of(q), 17'd65536);
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         run_packet(mk_tuser(vecs[i].len, vecs[i].dst, i), vecs[i].nbeats, vecs[i].lstrb,
                    vecs[i].admit, 3'(vecs[i].qid), i, 1'b0);
         @(posedge clk); #1;
         check($sformatf("v%0d_nwords", i), got_q.size(), vecs[i].exp_words);
         if (vecs[i].exp_words > 0 && got_q.size() > 0)
            check($sformatf("v%0d_last_bytes", i), got_q[got_q.size()-1].bytes, vecs[i].exp_lbytes);
         check($sformatf("v%0d_free", i), free_of(vecs[i].qid), vecs[i].exp_free);
         check($sformatf("v%0d_drop", i), drop_count, vecs[i].exp_drop);
         if (!vecs[i].admit) check($sformatf("v%0d_drop_stalls", i), drv_stalls, 0);
      end
      check("err_clean", err_overrun, 1'b0);

      // backpressure with a release landing on the admission cycle, then a saturating release
      rel_v = 1'b1; rel_q = 3'd5; rel_w = 17'd4;
      fork
         run_packet(mk_tuser(16'd60, 8'h20, 10), 2, 32'h0FFF_FFFF, 1'b1, 3'd5, 10, 1'b1);
         begin
            @(posedge clk); #1;
            rel_v = 1'b0;
            @(negedge clk);
            check("net_free5", free_of(5), 17'd65531);
            repeat (3) @(posedge clk);
            #1;
            rel_v = 1'b1; rel_w = 17'd9;
            @(posedge clk); #1;
            rel_v = 1'b0;
            @(negedge clk);
            check("sat_free5", free_of(5), 17'd65536);
         end
      join
      @(posedge clk); #1;
      check("bp_nwords", got_q.size(), 9);
      check("bp_free5_end", free_of(5), 17'd65536);

      // declared 8 bytes, sent 32: five words against a reservation of two
      run_packet(mk_tuser(16'd8, 8'h02, 11), 1, 32'hFFFF_FFFF, 1'b1, 3'd1, 11, 1'b0);
      @(posedge clk); #1;
      check("ovr_nwords", got_q.size(), 5);
      check("ovr_err", err_overrun, 1'b1);
      check("ovr_free1", free_of(1), 17'd65534);

      // reset while serialising
      bus.m_word_ready  = 1'b1;
      bus.s_axis_tuser  = mk_tuser(16'd60, 8'h10, 12);
      bus.s_axis_tdata  = beat_pat(12, 0);
      bus.s_axis_tstrb  = 32'hFFFF_FFFF;
      bus.s_axis_tlast  = 1'b0;
      bus.s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
      bus.s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_ser_word", {bus.m_word_valid, bus.m_word_sop, bus.m_word_data}, {1'b1, 1'b0, beat_pat(12, 0)[127:64]});
      check("mid_ser_free4", free_of(4), 17'd65527);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_valid", bus.m_word_valid, 1'b0);
      check("rst_tready", bus.s_axis_tready, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_valid", bus.m_word_valid, 1'b0);
      check("post_rst_data", bus.m_word_data, 64'd0);
      check("post_rst_drop", drop_count, 32'd0);
      check("post_rst_err", err_overrun, 1'b0);
      for (int q = 0; q < 8; q++) check($sformatf("post_rst_free%0d", q), free_of(q), 17'd65536);
      @(posedge clk); #1;
      run_packet(mk_tuser(16'd16, 8'h80, 13), 1, 32'h0000_FFFF, 1'b1, 3'd7, 13, 1'b0);
      @(posedge clk); #1;
      check("new_nwords", got_q.size(), 3);
      check("new_free7", free_of(7), 17'd65533);

      // no-space drop on the 16-word instance: need = 1 + 25 = 26
      sbus.s_axis_tuser  = mk_tuser(16'd200, 8'h01, 20);
      sbus.s_axis_tstrb  = 32'hFFFF_FFFF;
      sbus.s_axis_tvalid = 1'b1;
      for (int b = 0; b < 7; b++) begin
         sbus.s_axis_tdata = beat_pat(20, b);
         sbus.s_axis_tlast = (b == 6);
         @(negedge clk);
         check($sformatf("drop_beat%0d", b), {sbus.s_axis_tready, sbus.m_word_valid}, 2'b10);
         @(posedge clk); #1;
      end
      sbus.s_axis_tvalid = 1'b0;
      sbus.s_axis_tlast  = 1'b0;
      @(negedge clk);
      check("small_drop", s_drop, 32'd1);
      check("small_free0", s_free[0 +: SCW], 5'd16);
      check("small_valid", sbus.m_word_valid, 1'b0);
      check("small_err", s_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
